// File: rtl/reg_file_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_wb_pkg
// Brief    : Shared widths and constants for the write-back register file.
// Revision : 1.0
// ============================================================================
package reg_file_wb_pkg;

  localparam int         REG_LENGTH   = 32;
  localparam int         REG_ADDR_LEN = 5;
  localparam int         REG_NUM      = 2 ** REG_ADDR_LEN;
  localparam logic [4:0] REG_ZERO     = 5'd0;
  localparam logic       ENABLE       = 1'b1;
  localparam logic       DISABLE      = 1'b0;

endpackage : reg_file_wb_pkg
`default_nettype wire

// File: rtl/reg_read_mux.sv
`default_nettype none
// ============================================================================
// Module   : reg_read_mux
// Brief    : One GPR read port: reset/enable gating, r0, EX and latch forwarding.
// Revision : 1.0
// ============================================================================
module reg_read_mux
  import reg_file_wb_pkg::*;
#(
  parameter int REG_LENGTH   = reg_file_wb_pkg::REG_LENGTH,
  parameter int REG_ADDR_LEN = reg_file_wb_pkg::REG_ADDR_LEN,
  parameter bit BYPASS_EX    = 1'b1
) (
  input  logic                    rst,
  input  logic                    rd,
  input  logic [REG_ADDR_LEN-1:0] addr,
  input  logic                    ex_wr,
  input  logic [REG_ADDR_LEN-1:0] ex_addr,
  input  logic [REG_LENGTH-1:0]   ex_data,
  input  logic                    wb_valid,
  input  logic [REG_ADDR_LEN-1:0] wb_addr,
  input  logic [REG_LENGTH-1:0]   wb_data,
  input  logic [REG_LENGTH-1:0]   arr_data,
  output logic [REG_LENGTH-1:0]   data
);

  localparam logic [REG_ADDR_LEN-1:0] c_zero_addr = '0;

  // Newest source wins: live EX result, then the pending latch, then the array.
  always_comb begin
    data = '0;
    if (rst == ENABLE || rd == DISABLE) begin
      data = '0;
    end else if (addr == c_zero_addr) begin
      data = '0;
    end else if (BYPASS_EX && ex_wr && (ex_addr == addr)) begin
      data = ex_data;
    end else if (wb_valid && (wb_addr == addr)) begin
      data = wb_data;
    end else begin
      data = arr_data;
    end
  end

endmodule : reg_read_mux
`default_nettype wire

// File: rtl/reg_file_wb.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_wb
// Brief    : EX write-back latch plus 32-entry GPR array with two read ports.
// Revision : 1.0
// ============================================================================
module reg_file_wb
  import reg_file_wb_pkg::*;
#(
  parameter int REG_LENGTH   = reg_file_wb_pkg::REG_LENGTH,
  parameter int REG_ADDR_LEN = reg_file_wb_pkg::REG_ADDR_LEN,
  parameter bit BYPASS_EX    = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    regcWr,
  input  logic [REG_ADDR_LEN-1:0] regcAddr,
  input  logic [REG_LENGTH-1:0]   regcData,
  input  logic                    regaRd,
  input  logic [REG_ADDR_LEN-1:0] regaAddr,
  output logic [REG_LENGTH-1:0]   regaData,
  input  logic                    regbRd,
  input  logic [REG_ADDR_LEN-1:0] regbAddr,
  output logic [REG_LENGTH-1:0]   regbData,
  output logic                    wbValid,
  output logic [REG_ADDR_LEN-1:0] wbAddr
);

  localparam int                      c_num       = 2 ** REG_ADDR_LEN;
  localparam logic [REG_ADDR_LEN-1:0] c_zero_addr = '0;

  logic [REG_LENGTH-1:0]   r_gpr [c_num];
  logic                    r_wb_valid;
  logic [REG_ADDR_LEN-1:0] r_wb_addr;
  logic [REG_LENGTH-1:0]   r_wb_data;
  logic                    w_capture;

  // r0 writes never enter the latch, so the array entry 0 is never touched.
  assign w_capture = regcWr && (regcAddr != c_zero_addr);

  always_ff @(posedge clk) begin
    if (rst == ENABLE) begin
      for (int i = 0; i < c_num; i++) begin
        r_gpr[i] <= '0;
      end
      r_wb_valid <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
    end else begin
      if (r_wb_valid) begin
        r_gpr[r_wb_addr] <= r_wb_data;
      end
      r_wb_valid <= w_capture;
      r_wb_addr  <= w_capture ? regcAddr : c_zero_addr;
      r_wb_data  <= w_capture ? regcData : '0;
    end
  end

  assign wbValid = r_wb_valid;
  assign wbAddr  = r_wb_addr;

  reg_read_mux #(
    .REG_LENGTH  (REG_LENGTH),
    .REG_ADDR_LEN(REG_ADDR_LEN),
    .BYPASS_EX   (BYPASS_EX)
  ) u_read_a (
    .rst     (rst),
    .rd      (regaRd),
    .addr    (regaAddr),
    .ex_wr   (regcWr),
    .ex_addr (regcAddr),
    .ex_data (regcData),
    .wb_valid(r_wb_valid),
    .wb_addr (r_wb_addr),
    .wb_data (r_wb_data),
    .arr_data(r_gpr[regaAddr]),
    .data    (regaData)
  );

  reg_read_mux #(
    .REG_LENGTH  (REG_LENGTH),
    .REG_ADDR_LEN(REG_ADDR_LEN),
    .BYPASS_EX   (BYPASS_EX)
  ) u_read_b (
    .rst     (rst),
    .rd      (regbRd),
    .addr    (regbAddr),
    .ex_wr   (regcWr),
    .ex_addr (regcAddr),
    .ex_data (regcData),
    .wb_valid(r_wb_valid),
    .wb_addr (r_wb_addr),
    .wb_data (r_wb_data),
    .arr_data(r_gpr[regbAddr]),
    .data    (regbData)
  );

endmodule : reg_file_wb
`default_nettype wire

// File: tb/tb_reg_file_wb.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_wb
// Brief    : Directed and random checks of reg_file_wb against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_reg_file_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        regcWr;
  logic [4:0]  regcAddr;
  logic [31:0] regcData;
  logic        regaRd;
  logic [4:0]  regaAddr;
  logic [31:0] regaData;
  logic        regbRd;
  logic [4:0]  regbAddr;
  logic [31:0] regbData;
  logic        wbValid;
  logic [4:0]  wbAddr;

  int total = 0;
  int bad   = 0;

  // Model state: committed registers plus the one write still in flight.
  logic [31:0] mem [32];
  logic        pend_v;
  logic [4:0]  pend_a;
  logic [31:0] pend_d;

  reg_file_wb #(
    .REG_LENGTH  (32),
    .REG_ADDR_LEN(5),
    .BYPASS_EX   (1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .regcWr  (regcWr),
    .regcAddr(regcAddr),
    .regcData(regcData),
    .regaRd  (regaRd),
    .regaAddr(regaAddr),
    .regaData(regaData),
    .regbRd  (regbRd),
    .regbAddr(regbAddr),
    .regbData(regbData),
    .wbValid (wbValid),
    .wbAddr  (wbAddr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic rd, input logic [4:0] a);
    if (rst || !rd || a == 5'd0) return 32'h0;
    if (regcWr && regcAddr == a) return regcData;
    if (pend_v && pend_a == a)   return pend_d;
    return mem[a];
  endfunction

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      pend_v = 1'b0;
      pend_a = 5'd0;
      pend_d = 32'h0;
    end else begin
      if (pend_v) mem[pend_a] = pend_d;
      pend_v = regcWr && (regcAddr != 5'd0);
      pend_a = pend_v ? regcAddr : 5'd0;
      pend_d = pend_v ? regcData : 32'h0;
    end
  endtask

  // Apply inputs, let the read paths settle, compare against the model.
  task automatic drive(input logic r, input logic w, input logic [4:0] ca, input logic [31:0] cd,
                       input logic ard, input logic [4:0] aa, input logic brd, input logic [4:0] ba);
    rst = r; regcWr = w; regcAddr = ca; regcData = cd;
    regaRd = ard; regaAddr = aa; regbRd = brd; regbAddr = ba;
    #2;
    check("model_a", regaData, ref_read(regaRd, regaAddr));
    check("model_b", regbData, ref_read(regbRd, regbAddr));
    check("model_wbvalid", {31'h0, wbValid}, {31'h0, pend_v});
    check("model_wbaddr", {27'h0, wbAddr}, {27'h0, pend_a});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    pend_v = 1'b0; pend_a = 5'd0; pend_d = 32'h0;
    rst = 1'b1; regcWr = 1'b0; regcAddr = 5'd0; regcData = 32'h0;
    regaRd = 1'b0; regaAddr = 5'd0; regbRd = 1'b0; regbAddr = 5'd0;

    // Reset edge; reads are forced to 0 while rst is high.
    drive(1'b1, 1'b1, 5'd3, 32'hCAFE_F00D, 1'b1, 5'd3, 1'b1, 5'd3);
    check("rst_read_a", regaData, 32'h0);
    check("rst_read_b", regbData, 32'h0);
    tick();

    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(31 - i));
      check("init_a", regaData, 32'h0);
      check("init_b", regbData, 32'h0);
      check("init_wbvalid", {31'h0, wbValid}, 32'h0);
      tick();
    end

    // Single write with same-cycle bypass, latch visibility, then array.
    drive(1'b0, 1'b1, 5'd5, 32'h1234_5678, 1'b1, 5'd5, 1'b1, 5'd0);
    check("bypass_a", regaData, 32'h1234_5678);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5);
    check("latch_valid", {31'h0, wbValid}, 32'h1);
    check("latch_addr", {27'h0, wbAddr}, 32'd5);
    check("latch_read", regaData, 32'h1234_5678);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5);
    check("commit_valid", {31'h0, wbValid}, 32'h0);
    check("array_read", regaData, 32'h1234_5678);
    tick();

    // r0 writes are dropped.
    drive(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b1, 5'd0);
    check("r0_a", regaData, 32'h0);
    check("r0_b", regbData, 32'h0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0);
    check("r0_wbvalid", {31'h0, wbValid}, 32'h0);
    check("r0_b_after", regbData, 32'h0);
    tick();

    // Back-to-back writes to r7.
    drive(1'b0, 1'b1, 5'd7, 32'hA, 1'b0, 5'd0, 1'b1, 5'd7);
    check("b2b_first", regbData, 32'hA);
    tick();
    drive(1'b0, 1'b1, 5'd7, 32'hB, 1'b0, 5'd0, 1'b1, 5'd7);
    check("b2b_second", regbData, 32'hB);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd7);
    check("b2b_latch", regbData, 32'hB);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd7);
    check("b2b_array", regbData, 32'hB);
    tick();

    // Reset while a write is still in the latch.
    drive(1'b0, 1'b1, 5'd9, 32'hDEAD_BEEF, 1'b1, 5'd9, 1'b0, 5'd0);
    tick();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd9);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd5);
    check("rst_drop_r9", regaData, 32'h0);
    check("rst_clear_r5", regbData, 32'h0);
    check("rst_drop_valid", {31'h0, wbValid}, 32'h0);
    tick();

    // Read enables gate the ports independently.
    drive(1'b0, 1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    drive(1'b0, 1'b1, 5'd4, 32'h22, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd4);
    check("en_a", regaData, 32'h11);
    check("en_b_off", regbData, 32'h0);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd4);
    check("en_b_on", regbData, 32'h22);
    tick();

    // Random traffic concentrated on a few addresses to exercise forwarding.
    for (int n = 0; n < 500; n++) begin
      logic [4:0] a_w, a_a, a_b;
      a_w = 5'($urandom_range(0, 7));
      a_a = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      a_b = ($urandom_range(0, 3) == 0) ? a_a : 5'($urandom_range(0, 7));
      drive(($urandom_range(0, 40) == 0), ($urandom_range(0, 1) == 1), a_w, $urandom(),
            ($urandom_range(0, 7) != 0), a_a, ($urandom_range(0, 7) != 0), a_b);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_reg_file_wb
`default_nettype wire
